// File: rtl/resp_framer.sv
// Response framer: sends SYNC, cmd, len, payload and XOR checksum to uart_tx one
// byte at a time, with an optional per-byte timeout on the transmitter.
module resp_framer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TX_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [7:0]  i_cmd,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_data,
  input  logic        tx_done,
  output logic        tx_strobe,
  output logic [7:0]  wr_byte,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int unsigned   CW    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CW-1:0] TERM  = CW'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
  localparam bit            TO_EN = (TX_TIMEOUT > 0);

  logic [1:0]    r_state;
  logic [2:0]    r_idx;
  logic [2:0]    r_len;
  logic [7:0]    r_cmd;
  logic [31:0]   r_data;
  logic [7:0]    r_chk;
  logic [CW-1:0] r_cnt;
  logic          r_tx_strobe;
  logic [7:0]    r_wr_byte;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [2:0] w_len_clamp;
  logic [2:0] w_len_comp;
  logic [5:0] w_shamt;
  logic [2:0] w_last_idx;
  logic [2:0] w_idx_m3;
  logic [7:0] w_cur_byte;

  assign w_len_clamp = (i_len > 3'd4) ? 3'd4 : i_len;
  assign w_len_comp  = 3'd4 - w_len_clamp;
  // Payload is left-aligned on capture so byte k of the frame is always r_data[31-8k -: 8].
  assign w_shamt     = {w_len_comp, 3'b000};
  assign w_last_idx  = r_len + 3'd3;
  assign w_idx_m3    = r_idx - 3'd3;

  always_comb begin
    w_cur_byte = 8'h00;
    case (r_idx)
      3'd0:    w_cur_byte = SYNC_BYTE;
      3'd1:    w_cur_byte = r_cmd;
      3'd2:    w_cur_byte = {5'b00000, r_len};
      default: begin
        if (r_idx == w_last_idx) begin
          w_cur_byte = r_chk;
        end else begin
          case (w_idx_m3)
            3'd0:    w_cur_byte = r_data[31:24];
            3'd1:    w_cur_byte = r_data[23:16];
            3'd2:    w_cur_byte = r_data[15:8];
            3'd3:    w_cur_byte = r_data[7:0];
            default: w_cur_byte = 8'h00;
          endcase
        end
      end
    endcase
  end

  // Handshake with uart_tx: tx_strobe is a one-cycle pulse with wr_byte valid in that
  // same cycle; the next byte is only offered after a tx_done pulse seen in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_len       <= 3'd0;
      r_cmd       <= 8'h00;
      r_data      <= 32'h0;
      r_chk       <= 8'h00;
      r_cnt       <= '0;
      r_tx_strobe <= 1'b0;
      r_wr_byte   <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tx_strobe <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_cmd   <= i_cmd;
            r_len   <= w_len_clamp;
            r_data  <= i_data << w_shamt;
            r_chk   <= 8'h00;
            r_idx   <= 3'd0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_strobe <= 1'b1;
          r_wr_byte   <= w_cur_byte;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (r_idx == w_last_idx) begin
              r_state <= S_FINISH;
            end else begin
              r_idx <= r_idx + 3'd1;
              // The sync byte stays out of the checksum.
              if (r_idx != 3'd0) begin
                r_chk <= r_chk ^ r_wr_byte;
              end
              r_state <= S_SEND;
            end
          end else if (TO_EN && (r_cnt == TERM)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_strobe = r_tx_strobe;
  assign wr_byte   = r_wr_byte;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: doc/resp_framer.md
# resp_framer

Transmit-side counterpart of the host command parser: it turns a response (command echo plus up to 4 payload bytes) into a framed byte stream and feeds it to `uart_tx` one byte at a time using the strobe/done handshake. It runs in the 10 MHz UART clock domain between the command logic and `uart_tx`, so the host can read status and counters back from the glitcher. Framing is sync, cmd, len, payload, then an XOR checksum, with a per-byte timeout so a stalled transmitter cannot hang the block.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `TX_TIMEOUT`, default 0: clock cycles to wait for `tx_done` per byte. 0 disables the timeout.

Ports:
- `clk`  in  1  UART-domain clock (10 MHz). Single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  one-cycle request. Sampled only while `o_busy`=0.
- `i_cmd`  in  8  command code echoed in the frame.
- `i_len`  in  3  payload byte count, 0..4. Values 5..7 are clamped to 4.
- `i_data`  in  32  payload source.
- `tx_done`  in  1  one-cycle pulse from `uart_tx` at the end of each byte.
- `tx_strobe`  out  1  one-cycle pulse to `uart_tx`. `wr_byte` is valid in the same cycle.
- `wr_byte`  out  8  byte to transmit.
- `o_busy`  out  1  high from request acceptance until the frame ends.
- `o_done`  out  1  one-cycle pulse when a frame completes normally.
- `o_err`  out  1  one-cycle pulse when a frame is aborted on timeout.

## Operation
- Frame order: `SYNC_BYTE`, cmd, len (clamped value, zero-extended to 8 bits), payload, chk.
- chk = cmd ^ len ^ every payload byte. The sync byte is not included.
- Payload is the low L bytes of `i_data`, most significant of those first.
  - L=2 with `i_data`=0x0000BEEF sends BE, EF.
- On acceptance, cmd, clamped len and data are latched into internal registers. Later changes on the inputs do not affect a frame in flight.
- A 3-bit byte index counts up through the frame; the checksum accumulates in an 8-bit register.
- FSM states:
  - IDLE: `o_busy`=0. If `i_req`, latch the inputs, clear chk and index, go to SEND.
  - SEND: pulse `tx_strobe` with the current byte, clear the timeout counter, go to WAIT.
  - WAIT:
    - On `tx_done`: if the checksum byte was just sent, go to FINISH; otherwise advance the index, fold the sent byte into chk when it is cmd, len or payload, and go to SEND.
    - If `TX_TIMEOUT`>0 and the counter reaches `TX_TIMEOUT`-1 with no `tx_done`: pulse `o_err`, go to IDLE.
  - FINISH: pulse `o_done`, go to IDLE.
- `tx_done` is sampled only in WAIT. Pulses in IDLE, SEND or FINISH are ignored.
- `i_req` while `o_busy`=1 is dropped, not queued.
- If `tx_done` and the timeout terminal count land in the same cycle, `tx_done` wins.
- Reset mid-frame: all state and outputs return to reset values immediately. No partial-frame recovery. `uart_tx` finishes any byte it already holds.

## Timing
- Reset values: `tx_strobe`=0, `wr_byte`=8'h00, `o_busy`=0, `o_done`=0, `o_err`=0, FSM=IDLE.
- All outputs are registered.
- `i_req` accepted at edge N: `o_busy`=1 and `tx_strobe`=1 (sync byte) from N+1.
- `tx_done` seen at edge M in WAIT: next `tx_strobe` at M+1.
- After the checksum's `tx_done` at M: `o_done`=1 at M+1 and `o_busy`=0 at M+2. A new `i_req` is accepted from M+2.
- Frame length is L+4 bytes, so exactly L+4 `tx_strobe` pulses per complete frame.
- Timeout: `o_err` pulses `TX_TIMEOUT` cycles after the `tx_strobe` cycle. `o_busy` drops the following cycle.

## Test plan
- cmd=0x47, len=4, data=0xDEADBEEF, bench model acks each byte after 1000 cycles -> bytes A5 47 04 DE AD BE EF 61, one `o_done`, `o_err` never asserted.
- cmd=0x10, len=0 -> bytes A5 10 00 10. Exactly 4 strobes, then `o_done`.
- cmd=0x01, len=7, data=0x11223344 -> len clamped: bytes A5 01 04 11 22 33 44 41.
- `TX_TIMEOUT`=100, model never asserts `tx_done` -> one strobe (A5), `o_err` exactly 100 cycles later, `o_busy` low next cycle, no `o_done`.
- Second `i_req` plus `i_cmd`/`i_data` changes during a frame -> frame bytes unchanged, no second frame. Stray `tx_done` during SEND -> ignored, byte count stays L+4.
- `rst_n` low after the 3rd byte's strobe -> all outputs 0 asynchronously. After release, a fresh req with len=0 produces a clean 4-byte frame.
